writeback_stage: RTL and testbench

Final stage of the RV32I multi-cycle datapath. It sits directly upstream of the register file and drives its write port (we, rd_addr, rd_value). It selects the writeback source: ALU result, load data from the shared instruction/data memory, or PC+4. It also performs load byte/half extraction and sign/zero extension. A small FSM waits for memory read data and produces exactly one write per accepted instruction.

---
 rtl/writeback_stage_if.sv | 40 ++++
 rtl/writeback_stage.sv | 172 +++++++++++++++++
 tb/tb_writeback_stage.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_stage_if.sv
// writeback_stage_if
//   Groups the writeback stage's request handshake, memory read-return and
//   register-file write port into one bundle.
//   Request:    in_valid, in_ready, wb_sel, funct3, rd_addr_in, alu_result,
//               pc_plus4
//   Memory:     mem_rdata, mem_rvalid
//   Write port: we, rd_addr, rd_value
//   Status:     done, load_fault
//   Modports:   master = upstream/environment side, slave = writeback stage.
interface writeback_stage_if #(
    parameter int REG_WIDTH   = 32,
    parameter int RADDR_WIDTH = 5
);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             wb_sel;
    logic [2:0]             funct3;
    logic [RADDR_WIDTH-1:0] rd_addr_in;
    logic [REG_WIDTH-1:0]   alu_result;
    logic [REG_WIDTH-1:0]   pc_plus4;
    logic [REG_WIDTH-1:0]   mem_rdata;
    logic                   mem_rvalid;
    logic                   we;
    logic [RADDR_WIDTH-1:0] rd_addr;
    logic [REG_WIDTH-1:0]   rd_value;
    logic                   done;
    logic                   load_fault;

    modport master (
        output in_valid, wb_sel, funct3, rd_addr_in, alu_result, pc_plus4,
               mem_rdata, mem_rvalid,
        input  in_ready, we, rd_addr, rd_value, done, load_fault
    );

    modport slave (
        input  in_valid, wb_sel, funct3, rd_addr_in, alu_result, pc_plus4,
               mem_rdata, mem_rvalid,
        output in_ready, we, rd_addr, rd_value, done, load_fault
    );
endinterface

// File: rtl/writeback_stage.sv
// writeback_stage
//   Final stage of the RV32I multi-cycle datapath. Selects the writeback
//   source (ALU, load data, PC+4 or none), extracts and extends load lanes,
//   and produces exactly one register-file write per accepted request.
//   Ports:
//     clk  - clock, rising edge
//     rst  - synchronous active-high reset
//     bus  - writeback_stage_if.slave (request, memory return, write port,
//            done / load_fault status pulses)
module writeback_stage #(
    parameter int REG_WIDTH   = 32,
    parameter int RADDR_WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    writeback_stage_if.slave  bus
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WAIT_MEM = 2'd1;
    localparam logic [1:0] ST_WRITE    = 2'd2;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    logic [1:0]             state_q, state_d;
    logic [2:0]             f3_q, f3_d;
    logic [RADDR_WIDTH-1:0] rd_q, rd_d;
    logic [1:0]             addr_q, addr_d;
    logic                   we_q, we_d;
    logic                   done_q, done_d;
    logic                   fault_q, fault_d;
    logic [RADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [REG_WIDTH-1:0]   rd_value_q, rd_value_d;

    logic                   accept;
    logic                   misaligned;
    logic                   illegal;
    logic [7:0]             byte_lane [4];
    logic [15:0]            half_lane [2];
    logic [7:0]             byte_sel;
    logic [15:0]            half_sel;
    logic [REG_WIDTH-1:0]   load_ext;

    assign bus.in_ready = (state_q == ST_IDLE) && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    // Memory returns a word-aligned word; split it into its byte/half lanes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign byte_lane[gi] = bus.mem_rdata[8*gi +: 8];
        end
        for (gi = 0; gi < 2; gi++) begin : g_half
            assign half_lane[gi] = bus.mem_rdata[16*gi +: 16];
        end
    endgenerate

    // Fault decode uses the live request inputs since it is resolved at accept.
    always_comb begin
        illegal    = (bus.funct3 == 3'b011) || (bus.funct3 == 3'b110) ||
                     (bus.funct3 == 3'b111);
        misaligned = ((bus.funct3[1:0] == 2'b01) && bus.alu_result[0]) ||
                     ((bus.funct3 == 3'b010) && (bus.alu_result[1:0] != 2'b00));
    end

    // Lane extraction uses the captured address/type since the request inputs
    // are no longer valid while waiting for memory.
    always_comb begin
        byte_sel = byte_lane[addr_q];
        half_sel = half_lane[addr_q[1]];
        case (f3_q)
            3'b000:  load_ext = {{(REG_WIDTH-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{(REG_WIDTH-16){half_sel[15]}}, half_sel};
            3'b100:  load_ext = {{(REG_WIDTH-8){1'b0}}, byte_sel};
            3'b101:  load_ext = {{(REG_WIDTH-16){1'b0}}, half_sel};
            default: load_ext = bus.mem_rdata;
        endcase
    end

    // Outputs are computed on the transition into WRITE so the registered
    // write port is valid exactly during the WRITE cycle. Non-load results are
    // taken straight from the request at accept, so only the fields a load
    // still needs are held.
    always_comb begin
        state_d    = state_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        we_d       = 1'b0;
        done_d     = 1'b0;
        fault_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        rd_value_d = rd_value_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    f3_d   = bus.funct3;
                    rd_d   = bus.rd_addr_in;
                    addr_d = bus.alu_result[1:0];
                    if (bus.wb_sel == SEL_LOAD) begin
                        if (illegal || misaligned) begin
                            fault_d = 1'b1;
                        end else begin
                            state_d = ST_WAIT_MEM;
                        end
                    end else begin
                        state_d   = ST_WRITE;
                        done_d    = 1'b1;
                        // wb_sel 11 never writes; x0 is never written.
                        we_d      = (bus.wb_sel != 2'b11) && (bus.rd_addr_in != '0);
                        rd_addr_d = bus.rd_addr_in;
                        if (bus.wb_sel == SEL_ALU) begin
                            rd_value_d = bus.alu_result;
                        end else if (bus.wb_sel == SEL_PC4) begin
                            rd_value_d = bus.pc_plus4;
                        end else begin
                            rd_value_d = '0;
                        end
                    end
                end
            end
            ST_WAIT_MEM: begin
                if (bus.mem_rvalid) begin
                    state_d    = ST_WRITE;
                    done_d     = 1'b1;
                    we_d       = (rd_q != '0);
                    rd_addr_d  = rd_q;
                    rd_value_d = load_ext;
                end
            end
            ST_WRITE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            f3_q       <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_value_q <= '0;
        end else begin
            state_q    <= state_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
            rd_addr_q  <= rd_addr_d;
            rd_value_q <= rd_value_d;
        end
    end

    assign bus.we         = we_q;
    assign bus.done       = done_q;
    assign bus.load_fault = fault_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.rd_value   = rd_value_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage
//   Directed testbench for writeback_stage. Inputs change on the falling
//   edge; outputs are sampled on the falling edge after the active edge.
module tb_writeback_stage;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    writeback_stage_if #(.REG_WIDTH(32), .RADDR_WIDTH(5)) bus ();

    writeback_stage #(.REG_WIDTH(32), .RADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present a request for one edge, then scramble the request inputs so the
    // design must rely on what it captured.
    task automatic issue(input logic [1:0] sel, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc);
        bus.in_valid   = 1'b1;
        bus.wb_sel     = sel;
        bus.funct3     = f3;
        bus.rd_addr_in = rd;
        bus.alu_result = alu;
        bus.pc_plus4   = pc;
        @(negedge clk);
        bus.in_valid   = 1'b0;
        bus.wb_sel     = ~sel;
        bus.funct3     = ~f3;
        bus.rd_addr_in = ~rd;
        bus.alu_result = ~alu;
        bus.pc_plus4   = ~pc;
    endtask

    // Return one memory word for one edge; outputs then reflect that edge.
    task automatic mem_return(input logic [31:0] data);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = data;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'h5A5A_5A5A;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.we !== 1'b0 || bus.done !== 1'b0 || bus.load_fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: we=%b done=%b fault=%b, required 0 0 0",
                     bus.we, bus.done, bus.load_fault);
        end
        checks++;
        if (bus.rd_addr !== 5'd0 || bus.rd_value !== 32'd0) begin
            errors++;
            $display("FAIL reset_port: rd_addr=%0d rd_value=%h, required 0 0",
                     bus.rd_addr, bus.rd_value);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: in_ready=%b, required 0", bus.in_ready);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: in_ready=%b, required 1", bus.in_ready);
        end
        $display("reset: checked");
    endtask

    task automatic test_alu();
        issue(2'b00, 3'b000, 5'd5, 32'hDEAD_BEEF, 32'h0000_1004);
        checks++;
        if (bus.we !== 1'b1 || bus.done !== 1'b1 || bus.rd_addr !== 5'd5 ||
            bus.rd_value !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL alu_write: we=%b done=%b rd=%0d val=%h, required 1 1 5 deadbeef",
                     bus.we, bus.done, bus.rd_addr, bus.rd_value);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL alu_busy: in_ready=%b, required 0", bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.we !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL alu_after: we=%b done=%b in_ready=%b, required 0 0 1",
                     bus.we, bus.done, bus.in_ready);
        end
        $display("alu: rd=5 value=deadbeef");
    endtask

    task automatic test_pc4();
        issue(2'b10, 3'b000, 5'd1, 32'h1111_1111, 32'h0000_2008);
        checks++;
        if (bus.we !== 1'b1 || bus.rd_addr !== 5'd1 || bus.rd_value !== 32'h0000_2008) begin
            errors++;
            $display("FAIL pc4_write: we=%b rd=%0d val=%h, required 1 1 00002008",
                     bus.we, bus.rd_addr, bus.rd_value);
        end
        @(negedge clk);
        $display("pc4: rd=1 value=00002008");
    endtask

    // Run one load whose data returns `gap` idle cycles after accept.
    task automatic run_load(input string name, input logic [2:0] f3,
                            input logic [4:0] rd, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp,
                            input int gap);
        issue(2'b01, f3, rd, addr, 32'h0);
        for (int i = 0; i < gap; i++) begin
            checks++;
            if (bus.we !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s_wait: we=%b done=%b in_ready=%b, required 0 0 0",
                         name, bus.we, bus.done, bus.in_ready);
            end
            @(negedge clk);
        end
        mem_return(data);
        checks++;
        if (bus.we !== (rd != 5'd0) || bus.done !== 1'b1 || bus.rd_addr !== rd ||
            bus.rd_value !== exp) begin
            errors++;
            $display("FAIL %s_write: we=%b done=%b rd=%0d val=%h, required %b 1 %0d %h",
                     name, bus.we, bus.done, bus.rd_addr, bus.rd_value,
                     (rd != 5'd0), rd, exp);
        end
        @(negedge clk);
        checks++;
        if (bus.we !== 1'b0 || bus.done !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_after: we=%b done=%b in_ready=%b, required 0 0 1",
                     name, bus.we, bus.done, bus.in_ready);
        end
        $display("%s: addr=%h data=%h value=%h", name, addr, data, bus.rd_value);
    endtask

    task automatic test_loads();
        // Stray rvalid while idle must be ignored.
        mem_return(32'hFFFF_FFFF);
        checks++;
        if (bus.we !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL idle_rvalid: we=%b done=%b, required 0 0", bus.we, bus.done);
        end
        run_load("lb",  3'b000, 5'd7,  32'h0000_0103, 32'h8011_2233, 32'hFFFF_FF80, 2);
        run_load("lhu", 3'b101, 5'd8,  32'h0000_0202, 32'h8001_1234, 32'h0000_8001, 1);
        run_load("lh",  3'b001, 5'd8,  32'h0000_0202, 32'h8001_1234, 32'hFFFF_8001, 0);
        run_load("lbu", 3'b100, 5'd10, 32'h0000_0101, 32'h1234_A678, 32'h0000_00A6, 1);
        run_load("lw",  3'b010, 5'd11, 32'h0000_0300, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
        run_load("lh_low", 3'b001, 5'd12, 32'h0000_0400, 32'h0000_7FFE, 32'h0000_7FFE, 0);
        run_load("lb_x0", 3'b000, 5'd0, 32'h0000_0500, 32'h0000_0011, 32'h0000_0011, 0);
    endtask

    task automatic test_no_write();
        issue(2'b00, 3'b000, 5'd0, 32'h0000_0055, 32'h0);
        checks++;
        if (bus.we !== 1'b0 || bus.done !== 1'b1 || bus.rd_value !== 32'h0000_0055) begin
            errors++;
            $display("FAIL x0_alu: we=%b done=%b val=%h, required 0 1 00000055",
                     bus.we, bus.done, bus.rd_value);
        end
        @(negedge clk);
        issue(2'b11, 3'b000, 5'd9, 32'h1234_5678, 32'h0);
        checks++;
        if (bus.we !== 1'b0 || bus.done !== 1'b1 || bus.rd_addr !== 5'd9 ||
            bus.rd_value !== 32'd0) begin
            errors++;
            $display("FAIL none_sel: we=%b done=%b rd=%0d val=%h, required 0 1 9 0",
                     bus.we, bus.done, bus.rd_addr, bus.rd_value);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.we !== 1'b0) begin
            errors++;
            $display("FAIL none_after: we=%b done=%b, required 0 0", bus.we, bus.done);
        end
        $display("no_write: x0 and wb_sel=11 retired without write");
    endtask

    task automatic check_fault(input string name, input logic [2:0] f3,
                               input logic [31:0] addr);
        issue(2'b01, f3, 5'd6, addr, 32'h0);
        checks++;
        if (bus.load_fault !== 1'b1 || bus.we !== 1'b0 || bus.done !== 1'b0 ||
            bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s: fault=%b we=%b done=%b in_ready=%b, required 1 0 0 1",
                     name, bus.load_fault, bus.we, bus.done, bus.in_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.load_fault !== 1'b0 || bus.we !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL %s_after: fault=%b we=%b done=%b, required 0 0 0",
                     name, bus.load_fault, bus.we, bus.done);
        end
        $display("%s: f3=%b addr=%h faulted", name, f3, addr);
    endtask

    task automatic test_faults();
        check_fault("fault_lw_mis", 3'b010, 32'h0000_0102);
        check_fault("fault_f3_011", 3'b011, 32'h0000_0100);
        check_fault("fault_lhu_mis", 3'b101, 32'h0000_0203);
        check_fault("fault_f3_111", 3'b111, 32'h0000_0000);
    endtask

    task automatic test_back_to_back();
        bus.in_valid   = 1'b1;
        bus.wb_sel     = 2'b00;
        bus.rd_addr_in = 5'd3;
        bus.alu_result = 32'h0000_0001;
        @(negedge clk);
        // Keep valid asserted with a new request; it must not be taken in WRITE.
        bus.rd_addr_in = 5'd4;
        bus.alu_result = 32'h0000_0002;
        checks++;
        if (bus.we !== 1'b1 || bus.rd_addr !== 5'd3 || bus.rd_value !== 32'h1) begin
            errors++;
            $display("FAIL b2b_first: we=%b rd=%0d val=%h, required 1 3 00000001",
                     bus.we, bus.rd_addr, bus.rd_value);
        end
        @(negedge clk);
        checks++;
        if (bus.we !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: we=%b in_ready=%b, required 0 1", bus.we, bus.in_ready);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++;
        if (bus.we !== 1'b1 || bus.rd_addr !== 5'd4 || bus.rd_value !== 32'h2) begin
            errors++;
            $display("FAIL b2b_second: we=%b rd=%0d val=%h, required 1 4 00000002",
                     bus.we, bus.rd_addr, bus.rd_value);
        end
        @(negedge clk);
        $display("back_to_back: rd3 then rd4 two cycles apart");
    endtask

    task automatic test_reset_mid_load();
        int stray;
        stray = 0;
        issue(2'b01, 3'b010, 5'd4, 32'h0000_0100, 32'h0);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rml_ready_in_rst: in_ready=%b, required 0", bus.in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rml_ready_after: in_ready=%b, required 1", bus.in_ready);
        end
        @(negedge clk);
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'h1357_9BDF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.mem_rvalid = 1'b0;
            if (bus.we !== 1'b0 || bus.done !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rml_no_write: stray write/done cycles=%0d, required 0", stray);
        end
        $display("reset_mid_load: request abandoned");
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.wb_sel     = 2'b00;
        bus.funct3     = 3'b000;
        bus.rd_addr_in = 5'd0;
        bus.alu_result = 32'd0;
        bus.pc_plus4   = 32'd0;
        bus.mem_rdata  = 32'd0;
        bus.mem_rvalid = 1'b0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_pc4();
        test_loads();
        test_no_write();
        test_faults();
        test_back_to_back();
        test_reset_mid_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
